idct_block_sequencer: RTL and testbench

- Sequences one 8x8 JPEG IDCT block through the memory-mapped row IDCT and column IDCT datapaths without CPU involvement.
- Fetches 64 coefficient words from working memory (0x4000_0000 region).
- Runs 8 row passes and 8 column passes through an internal transpose buffer, then writes 64 result words back.
- Sits between the AXI memory/peripheral model and the two IDCT datapaths; the CPU only programs the addresses, pulses start and polls done.

---
 rtl/idct_seq_pkg.sv | 21 ++
 rtl/idct_tbuf.sv | 46 ++++
 rtl/idct_block_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_idct_block_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_seq_pkg.sv
// Shared types and constants for the 8x8 IDCT block sequencer.
package idct_seq_pkg;

  localparam int unsigned N           = 8;
  localparam int unsigned WORDS       = 64;
  localparam int unsigned ADDR_STRIDE = 4;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    ROW_ISSUE,
    ROW_WAIT,
    ROW_STORE,
    COL_ISSUE,
    COL_WAIT,
    COL_STORE,
    STORE,
    DONE
  } state_e;

endpackage

// File: rtl/idct_tbuf.sv
// 8x8 word transpose buffer: single-word access plus whole-row and whole-column access.
module idct_tbuf
  import idct_seq_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [5:0]      waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [5:0]      raddr_i,
  output logic [DW-1:0]   rdata_o,
  input  logic [2:0]      row_sel_i,
  input  logic            row_we_i,
  input  logic [N*DW-1:0] row_wdata_i,
  output logic [N*DW-1:0] row_rdata_o,
  input  logic [2:0]      col_sel_i,
  input  logic            col_we_i,
  input  logic [N*DW-1:0] col_wdata_i,
  output logic [N*DW-1:0] col_rdata_o
);

  logic [DW-1:0] mem_q [N][N];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i[5:3]][waddr_i[2:0]] <= wdata_i;
    if (row_we_i) begin
      for (int unsigned j = 0; j < N; j++) mem_q[row_sel_i][j[2:0]] <= row_wdata_i[j*DW +: DW];
    end
    if (col_we_i) begin
      for (int unsigned i = 0; i < N; i++) mem_q[i[2:0]][col_sel_i] <= col_wdata_i[i*DW +: DW];
    end
  end

  assign rdata_o = mem_q[raddr_i[5:3]][raddr_i[2:0]];

  always_comb begin
    row_rdata_o = '0;
    col_rdata_o = '0;
    for (int unsigned j = 0; j < N; j++) begin
      row_rdata_o[j*DW +: DW] = mem_q[row_sel_i][j[2:0]];
      col_rdata_o[j*DW +: DW] = mem_q[j[2:0]][col_sel_i];
    end
  end

endmodule

// File: rtl/idct_block_sequencer.sv
// Moves one 8x8 block memory -> row IDCT -> column IDCT -> memory with no CPU involvement.
module idct_block_sequencer
  import idct_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned DW      = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [31:0]     src_addr,
  input  logic [31:0]     dst_addr,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic [N*DW-1:0] row_x,
  output logic            row_rst,
  input  logic            row_rdy,
  input  logic [N*DW-1:0] row_y,
  output logic [N*DW-1:0] col_x,
  output logic            col_rst,
  input  logic            col_rdy,
  input  logic [N*DW-1:0] col_y
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [5:0]    k_q, k_d;
  logic [2:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   src_q, src_d, dst_q, dst_d;
  logic          err_q, err_d;

  logic            buf_we, row_we, col_we, accept;
  logic [DW-1:0]   buf_rdata;
  logic [N*DW-1:0] row_rd, col_rd;

  idct_tbuf #(.DW(DW)) u_tbuf (
    .clk_i       (clk),
    .we_i        (buf_we),
    .waddr_i     (k_q),
    .wdata_i     (mem_rdata),
    .raddr_i     (k_q),
    .rdata_o     (buf_rdata),
    .row_sel_i   (idx_q),
    .row_we_i    (row_we),
    .row_wdata_i (row_y),
    .row_rdata_o (row_rd),
    .col_sel_i   (idx_q),
    .col_we_i    (col_we),
    .col_wdata_i (col_y),
    .col_rdata_o (col_rd)
  );

  assign err = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      tmo_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    tmo_d     = tmo_q;
    src_d     = src_q;
    dst_d     = dst_q;
    err_d     = err_q;
    busy      = 1'b1;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    row_x     = '0;
    col_x     = '0;
    row_rst   = 1'b1;
    col_rst   = 1'b1;
    buf_we    = 1'b0;
    row_we    = 1'b0;
    col_we    = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          src_d   = src_addr & ~32'(ADDR_STRIDE - 1);
          dst_d   = dst_addr & ~32'(ADDR_STRIDE - 1);
          err_d   = 1'b0;
          k_d     = '0;
          pend_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mem_req  = !pend_q;
        mem_addr = src_q + 32'(k_q) * ADDR_STRIDE;
        accept   = mem_req && mem_ready;
        // Data may return in the same cycle the request is accepted.
        if (mem_rvalid && (pend_q || accept)) begin
          buf_we = 1'b1;
          pend_d = 1'b0;
          k_d    = k_q + 1'b1;
          if (k_q == 6'(WORDS - 1)) begin
            idx_d   = '0;
            state_d = ROW_ISSUE;
          end
        end else if (accept) begin
          pend_d = 1'b1;
        end
      end
      ROW_ISSUE: begin
        row_x   = row_rd;
        tmo_d   = '0;
        state_d = ROW_WAIT;
      end
      ROW_WAIT: begin
        row_x   = row_rd;
        row_rst = 1'b0;
        // Capture y on the rdy edge itself, before the datapath is put back in reset.
        if (row_rdy && (tmo_q != '0)) begin
          row_we  = 1'b1;
          state_d = ROW_STORE;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ROW_STORE: begin
        row_x   = row_rd;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == 3'(N - 1)) ? COL_ISSUE : ROW_ISSUE;
      end
      COL_ISSUE: begin
        col_x   = col_rd;
        tmo_d   = '0;
        state_d = COL_WAIT;
      end
      COL_WAIT: begin
        col_x   = col_rd;
        col_rst = 1'b0;
        if (col_rdy && (tmo_q != '0)) begin
          col_we  = 1'b1;
          state_d = COL_STORE;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COL_STORE: begin
        col_x = col_rd;
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'(N - 1)) begin
          k_d     = '0;
          state_d = STORE;
        end else begin
          state_d = COL_ISSUE;
        end
      end
      STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_q + 32'(k_q) * ADDR_STRIDE;
        mem_wdata = buf_rdata;
        if (mem_ready) begin
          k_d = k_q + 1'b1;
          if (k_q == 6'(WORDS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_idct_block_sequencer.sv
// Directed bench for idct_block_sequencer with memory/datapath models and a write scoreboard.
module tb_idct_block_sequencer;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  src_addr = '0, dst_addr = '0;
  logic         busy, done, err, mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_ready = 1'b1, mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic [255:0] row_x, row_y, col_x, col_y;
  logic         row_rst, col_rst;
  logic         row_rdy = 1'b0, col_rdy = 1'b0;

  idct_block_sequencer #(.TIMEOUT(TMO), .DW(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .row_x(row_x), .row_rst(row_rst), .row_rdy(row_rdy), .row_y(row_y),
    .col_x(col_x), .col_rst(col_rst), .col_rdy(col_rdy), .col_y(col_y)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int reads, writes, done_cnt;
  logic [31:0] exp_raddr, exp_waddr;
  logic [31:0] exp_q[$];
  logic [31:0] mem [1024];
  logic [31:0] src_img [64];

  int ready_mode = 0, rv_delay = 1;
  int row_lat = 3, col_lat = 3;
  bit row_en = 1, col_en = 1;
  logic [31:0] row_mul = 1, row_add = 0, row_mix = 0;
  logic [31:0] col_mul = 1, col_add = 0, col_mix = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: all handshakes are observed mid-cycle, on the falling edge.
  initial begin
    int rphase = 0, rcnt = 0;
    bit rpend = 0;
    logic [31:0] rbuf = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rpend = 0; mem_rvalid = 1'b0; rphase = 0;
      end else begin
        if (done === 1'b1) done_cnt++;
        mem_rvalid = 1'b0;
        if (rpend) begin
          rcnt--;
          if (rcnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rbuf; rpend = 0; end
        end
        rphase = (rphase + 1) % 3;
        mem_ready = (ready_mode == 0) || (rphase == 0);
        if (mem_req && mem_ready) begin
          if (mem_we) begin
            writes++;
            chk("wr_addr", mem_addr, exp_waddr);
            exp_waddr += 4;
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("wr_data", mem_wdata, exp_q.pop_front());
            mem[mem_addr[11:2]] = mem_wdata;
          end else begin
            reads++;
            chk("rd_addr", mem_addr, exp_raddr);
            exp_raddr += 4;
            rbuf = mem[mem_addr[11:2]];
            rpend = 1;
            rcnt = rv_delay;
          end
        end
      end
    end
  end

  // Datapath models: rdy rises lat+1 falling edges after rst drops; y_j = mul*x_j + add + mix*x_0.
  initial begin
    int rc = 0, cc = 0;
    forever begin
      @(negedge clk);
      rc = row_rst ? 0 : rc + 1;
      cc = col_rst ? 0 : cc + 1;
      row_rdy = row_en && !row_rst && (rc > row_lat);
      col_rdy = col_en && !col_rst && (cc > col_lat);
    end
  end

  always_comb begin
    row_y = '0;
    col_y = '0;
    for (int j = 0; j < 8; j++) begin
      row_y[j*32 +: 32] = row_x[j*32 +: 32] * row_mul + row_add + row_mix * row_x[31:0];
      col_y[j*32 +: 32] = col_x[j*32 +: 32] * col_mul + col_add + col_mix * col_x[31:0];
    end
  end

  task automatic load_src(input int base_word);
    for (int k = 0; k < 64; k++) mem[base_word + k] = src_img[k];
  endtask

  task automatic build_expected();
    logic [31:0] a [8][8];
    logic [31:0] b [8][8];
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) a[r][j] = src_img[r*8 + j];
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) b[r][j] = a[r][j] * row_mul + row_add + row_mix * a[r][0];
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 8; c++) a[i][c] = b[i][c] * col_mul + col_add + col_mix * b[0][c];
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(a[k/8][k%8]);
  endtask

  task automatic start_block(input logic [31:0] s, input logic [31:0] d);
    exp_raddr = s & ~32'd3;
    exp_waddr = d & ~32'd3;
    reads = 0; writes = 0; done_cnt = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic complete(input string tag, input int exp_writes, output int n);
    wait_done(5000, n);
    chk({tag, ":done"}, done, 1);
    chk({tag, ":err"}, err, 0);
    @(negedge clk);
    chk({tag, ":done_pulse"}, done, 0);
    chk({tag, ":busy_low"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({tag, ":done_count"}, done_cnt, 1);
    chk({tag, ":reads"}, reads, 64);
    chk({tag, ":writes"}, writes, exp_writes);
    chk({tag, ":sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int n, m;
    repeat (3) @(negedge clk);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:err", err, 0);
    chk("rst:mem_req", mem_req, 0);
    chk("rst:mem_we", mem_we, 0);
    chk("rst:mem_addr", mem_addr, 0);
    chk("rst:mem_wdata", mem_wdata, 0);
    chk("rst:row_x", row_x, 0);
    chk("rst:col_x", col_x, 0);
    chk("rst:row_rst", row_rst, 1);
    chk("rst:col_rst", col_rst, 1);
    resetn = 1'b1;
    @(negedge clk);

    // Identity datapaths, rdy 3 cycles after rst falls.
    for (int k = 0; k < 64; k++) src_img[k] = k;
    load_src(0);
    build_expected();
    start_block(32'h4000_0000, 32'h4000_0400);
    chk("ident:busy_after_start", busy, 1);
    complete("ident", 64, n);

    // Zero-wait memory, 1-cycle rdy; mixing models expose row/column orientation.
    row_lat = 1; col_lat = 1; row_mix = 1; col_mix = 1;
    for (int k = 0; k < 64; k++) src_img[k] = 3*k + 1;
    load_src(0);
    build_expected();
    start_block(32'h4000_0000, 32'h4000_0400);
    complete("lat", 64, n);
    chk("lat:cycles", n + 1, 64*2 + 16*4 + 64 + 1);
    row_mix = 0; col_mix = 0; row_lat = 3; col_lat = 3;

    // Row y=x+1, column y=2x on a sparse block.
    row_add = 1; col_mul = 2;
    for (int k = 0; k < 64; k++) src_img[k] = (k == 9) ? 5 : 0;
    load_src(0);
    build_expected();
    chk("sparse:model_w9", exp_q[9], 12);
    chk("sparse:model_w0", exp_q[0], 2);
    start_block(32'h4000_0000, 32'h4000_0400);
    complete("sparse", 64, n);
    row_add = 0; col_mul = 1;

    // Slow memory with unaligned programmed addresses.
    ready_mode = 1; rv_delay = 4;
    for (int k = 0; k < 64; k++) src_img[k] = k;
    load_src(128);
    build_expected();
    start_block(32'h4000_0202, 32'h4000_0701);
    complete("slow", 64, n);
    ready_mode = 0; rv_delay = 1;

    // Column datapath never answers.
    col_en = 0;
    load_src(0);
    exp_q.delete();
    start_block(32'h4000_0000, 32'h4000_0400);
    n = 0;
    while (col_rst && n < 3000) begin @(negedge clk); n++; end
    chk("tmo:col_wait_entered", col_rst, 0);
    m = 0;
    while (!done && m < 100) begin @(negedge clk); m++; end
    chk("tmo:done_delay", m, TMO + 1);
    chk("tmo:err", err, 1);
    chk("tmo:col_rst", col_rst, 1);
    chk("tmo:row_rst", row_rst, 1);
    chk("tmo:mem_req", mem_req, 0);
    repeat (4) @(negedge clk);
    chk("tmo:err_sticky", err, 1);
    chk("tmo:done_count", done_cnt, 1);
    chk("tmo:reads", reads, 64);
    chk("tmo:writes", writes, 0);
    col_en = 1;

    // Second start during LOAD is ignored; also clears the sticky err.
    for (int k = 0; k < 64; k++) mem[192 + k] = 32'hFFFF_0000 + k;
    for (int k = 0; k < 64; k++) src_img[k] = 100 + k;
    load_src(0);
    build_expected();
    start_block(32'h4000_0000, 32'h4000_0400);
    chk("dbl:err_cleared", err, 0);
    repeat (10) @(negedge clk);
    src_addr = 32'h4000_0300; dst_addr = 32'h4000_0800; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    complete("dbl", 64, n);

    // Asynchronous reset while a row pass is waiting, then a fresh block.
    for (int k = 0; k < 64; k++) src_img[k] = k;
    load_src(0);
    build_expected();
    start_block(32'h4000_0000, 32'h4000_0400);
    n = 0;
    while (row_rst && n < 3000) begin @(negedge clk); n++; end
    chk("arst:row_wait_entered", row_rst, 0);
    resetn = 1'b0;
    #1;
    chk("arst:busy", busy, 0);
    chk("arst:row_rst", row_rst, 1);
    chk("arst:mem_req", mem_req, 0);
    chk("arst:row_x", row_x, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    build_expected();
    start_block(32'h4000_0000, 32'h4000_0400);
    complete("arst_fresh", 64, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (observed hang, required completion)");
    $fatal(1);
  end

endmodule
